aes_inv_subbytes_serial: RTL
============================

# aes_inv_subbytes_serial

Byte-serial InvShiftRows + InvSubBytes stage for the AES-128 decryption datapath. It accepts one 128-bit state word over a valid/ready handshake and pushes its 16 bytes, one per cycle, through a single `aes_inv_sbox` instance. It assembles the result in an output register and presents it downstream over a second valid/ready handshake. It sits between the round-key/InvMixColumns stage and the next decryption round, trading throughput for one S-box instead of sixteen.

## Interface
- `INV_SHIFT`, default 1: 1 = apply InvShiftRows before InvSubBytes; 0 = InvSubBytes only (identity byte mapping).
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: upstream has a state word on `in_data`.
- `in_ready` out 1: block can accept a word this cycle.
- `in_data` in 128: input state; byte i = bits [127-8i:120-8i], row r = i%4, column c = i/4.
- `out_valid` out 1: `out_data` holds a completed result.
- `out_ready` in 1: downstream accepts `out_data` this cycle.
- `out_data` out 128: result state, same byte ordering as `in_data`.
- `busy` out 1: high while bytes are being substituted.

## Operation
- The block has three states: IDLE, BUSY and DONE. Reset puts it in IDLE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`, latch `in_data` into the 128-bit input register, clear the 4-bit byte counter `cnt` to 0, and go to BUSY.
- **BUSY**
  - `busy` = 1 and `in_ready` = 0.
  - Each cycle computes output byte k = `cnt`, with r = k%4 and c = k/4.
  - Source byte index s = r + 4*((c - r) mod 4) when `INV_SHIFT` = 1, and s = k when `INV_SHIFT` = 0.
  - The selected input byte drives the `aes_inv_sbox` input combinationally. The S-box output is written to byte k of the output register at the clock edge.
  - `cnt` increments by 1. When `cnt` = 15 is written, go to DONE; `cnt` wraps to 0.
- **DONE**
  - `out_valid` = 1 and `in_ready` = 0.
  - When `out_ready` = 1, the transfer completes and the block returns to IDLE.
  - `out_data` stays stable from the assertion of `out_valid` until the transfer completes.
- `out_data` is never cleared between blocks. Each new block overwrites it byte by byte during BUSY; downstream must sample it only when `out_valid` = 1.
- `in_data` and `in_valid` are ignored in BUSY and DONE; no second word is buffered.
- Reset asserted mid-operation aborts the block immediately. No partial result is ever presented.

## Timing
- Reset values:
  - state = IDLE and `cnt` = 0.
  - Input and output registers = 0.
  - `in_ready` = 1; `out_valid` = 0; `busy` = 0; `out_data` = 0.
- Latency: a word accepted at edge T gives `out_valid` = 1 after edge T+16.
- Exactly 16 cycles are spent in BUSY.
- Minimum period is 18 cycles per block: 1 IDLE accept cycle, 16 BUSY cycles and 1 DONE cycle with `out_ready` = 1.
- Backpressure: `out_ready` = 0 holds DONE indefinitely, keeping `out_valid` and `out_data` constant.
- `in_valid` and `out_ready` may toggle arbitrarily; only the sampled edge matters.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `rst_n` = 0 asynchronously mid-cycle → `in_ready` = 1, `out_valid` = 0, `busy` = 0 and `out_data` = 0 immediately, without waiting for a clock edge.
- **Uniform state:** `in_data` = 128'h6363…63 with `out_ready` = 1 → `out_valid` rises 16 cycles after acceptance with `out_data` = 128'h0; `busy` is high for exactly 16 cycles.
- **Shift ordering:** `INV_SHIFT` = 1, `in_data` = 128'h000102030405060708090a0b0c0d0e0f → `out_data` = 128'h52f3a3383009d79ebf366afb8140a5d5.
- **Shift disabled:** the same input with `INV_SHIFT` = 0 → `out_data` = 128'h52096ad53036a538bf40a39e81f3d7fb.
- **Backpressure and busy input:**
  - Hold `out_ready` = 0 for 10 cycles after `out_valid` rises → `out_data` is unchanged and `in_ready` = 0.
  - A second `in_valid` pulse during BUSY/DONE is ignored.
  - Releasing `out_ready` returns the block to IDLE in 1 cycle, and the next word is processed correctly.
- **Reset mid-BUSY:** assert `rst_n` = 0 at `cnt` = 7 → state returns to IDLE with all outputs at their reset values; the following block produces a correct result and no stale bytes.

Source files
------------

// File: rtl/aes_inv_subbytes_serial.sv
// Byte-serial InvShiftRows + InvSubBytes: one inverse S-box shared across the
// 16 bytes of an AES state, with valid/ready handshakes on both sides.

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc;
    logic [7:0] pp;
    acc = 8'h00;
    pp  = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ pp;
      pp = xtime(pp);
    end
    return acc;
  endfunction

  // v^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] v);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = v;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] v);
    return {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    y = gf_inv(affine_inv(a));
  end

endmodule

module aes_inv_subbytes_serial #(
  parameter int INV_SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nx;
  logic [3:0]   cnt;
  logic [127:0] in_reg;
  logic [127:0] out_reg;
  logic [1:0]   row, col, src_col;
  logic [3:0]   src;
  logic [7:0]   sbox_in, sbox_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)    state_nx = BUSY;
      BUSY:    if (cnt == 4'd15) state_nx = DONE;
      DONE:    if (out_ready)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == BUSY);
    out_valid = (state == DONE);
  end

  // Output byte k = cnt reads source byte s; byte i lives at bit offset 8*(15-i)
  assign row     = cnt[1:0];
  assign col     = cnt[3:2];
  assign src_col = col - row;
  assign src     = (INV_SHIFT != 0) ? {src_col, row} : cnt;
  assign sbox_in = in_reg[{~src, 3'b000} +: 8];

  aes_inv_sbox u_sbox (
    .a (sbox_in),
    .y (sbox_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      in_reg  <= 128'd0;
      out_reg <= 128'd0;
    end else if (state == IDLE && in_valid) begin
      in_reg <= in_data;
      cnt    <= 4'd0;
    end else if (state == BUSY) begin
      out_reg[{~cnt, 3'b000} +: 8] <= sbox_out;
      cnt <= cnt + 4'd1;
    end
  end

  assign out_data = out_reg;

endmodule
